// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select encodings
// (also imported by the controller), fetch FSM states and the default reset PC.
package ifu_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    EXEC  = 2'b10
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/ifu_npc.sv
// Combinational next-PC computation. JR (npc_op 11) is only implemented when
// IFU_JR_EN is defined; otherwise it falls back to PC+4 and never flags misalign.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  npc_op_e     npc_op_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_i + 32'd4;

`ifndef IFU_JR_EN
  logic unused_rs_data;
  assign unused_rs_data = ^rs_data_i;
`endif

  always_comb begin
    next_pc_o  = pc_plus4;
    misalign_o = 1'b0;
    case (npc_op_i)
      NPC_BRANCH: next_pc_o = pc_plus4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
      NPC_JUMP:   next_pc_o = {pc_plus4[31:28], imm26_i, 2'b00};
`ifdef IFU_JR_EN
      NPC_JR: begin
        next_pc_o  = {rs_data_i[31:2], 2'b00};
        misalign_o = |rs_data_i[1:0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over the imem handshake and holds
// the instruction until retire. IFU_JR_EN enables register-indirect jumps.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  ifu_if.master       imem,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [1:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_misalign
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        npc_misalign;
  logic        capture;
  logic        retire_fire;

  ifu_npc u_npc (
    .pc_i       (pc_q),
    .npc_op_i   (npc_op_e'(npc_op)),
    .imm16_i    (imm16),
    .imm26_i    (imm26),
    .rs_data_i  (rs_data),
    .next_pc_o  (next_pc),
    .misalign_o (npc_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (imem.imem_ready)  state_d = WAIT;
      WAIT:    if (imem.imem_rvalid) state_d = EXEC;
      EXEC:    if (retire)           state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Request is masked during the reset cycle so an abandoned fetch is never re-issued.
  always_comb begin
    imem.imem_req  = (state_q == FETCH) && !rst;
    imem.imem_addr = pc_q;
  end

  assign capture     = (state_q == WAIT) && imem.imem_rvalid;
  assign retire_fire = (state_q == EXEC) && retire;

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    if (capture) begin
      instr_d       = imem.imem_rdata;
      instr_valid_d = 1'b1;
    end
    if (retire_fire) begin
      pc_d          = next_pc;
      instr_valid_d = 1'b0;
      misalign_d    = misalign_q | npc_misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: transaction-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        retire;
  logic [1:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_misalign;

  int passed = 0;
  int total  = 0;

  ifu_if bus ();

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .retire      (retire),
    .npc_op      (npc_op),
    .imm16       (imm16),
    .imm26       (imm26),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_misalign (pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: an instruction is either being requested, outstanding,
  // or held for execution; the PC changes only when a held instruction retires.
  logic        m_live    = 1'b0;
  logic [31:0] m_pc      = '0;
  logic [31:0] m_instr   = '0;
  logic        m_valid   = 1'b0;
  logic        m_pending = 1'b0;
  logic        m_mis     = 1'b0;

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [1:0] op,
                                            input logic [15:0] i16, input logic [25:0] i26);
    int off;
    off = int'($signed(i16)) * 4;
    case (op)
      2'd1: return p + 32'd4 + 32'(off);
      2'd2: return ((p + 32'd4) & 32'hF000_0000) | (32'(i26) * 32'd4);
`ifdef IFU_JR_EN
      2'd3: return rs_data & 32'hFFFF_FFFC;
`endif
      default: return p + 32'd4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live    = 1'b1;
      m_pc      = 32'h0000_3000;
      m_instr   = '0;
      m_valid   = 1'b0;
      m_pending = 1'b0;
      m_mis     = 1'b0;
    end else if (m_live) begin
      if (m_valid && retire) begin
`ifdef IFU_JR_EN
        if (npc_op == 2'b11 && rs_data[1:0] != 2'b00) m_mis = 1'b1;
`endif
        m_pc    = model_npc(m_pc, npc_op, imm16, imm26);
        m_valid = 1'b0;
      end else if (m_pending && bus.imem_rvalid) begin
        m_instr   = bus.imem_rdata;
        m_valid   = 1'b1;
        m_pending = 1'b0;
      end else if (!m_valid && !m_pending && bus.imem_ready) begin
        m_pending = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic exp_req;
      exp_req = !rst && !m_valid && !m_pending;
      check("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("instr", instr, m_instr);
      check("pc_misalign", 32'(pc_misalign), 32'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Non-retire cycles carry junk select/immediates: they must not be sampled.
  task automatic idle();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0BAD_0BAD;
    retire  = 1'b0;
    npc_op  = 2'b10;
    imm16   = 16'h5555;
    imm26   = 26'h2AA_AAAA;
    rs_data = 32'hFFFF_FFFF;
    #1;
  endtask

  task automatic do_instr(input logic [31:0] rd, input logic [1:0] op,
                          input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
    idle();
    bus.imem_ready = 1'b1;
    tick();
    idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = rd;
    tick();
    idle();
    retire  = 1'b1;
    npc_op  = op;
    imm16   = i16;
    imm26   = i26;
    rs_data = rs;
    tick();
    idle();
  endtask

  logic [31:0] exp_jr_addr;
  logic        exp_mis;

  initial begin
`ifdef IFU_JR_EN
    exp_jr_addr = 32'h0000_3020;
    exp_mis     = 1'b1;
`else
    exp_jr_addr = 32'h0000_3048;
    exp_mis     = 1'b0;
`endif
    rst = 1'b1;
    idle();
    tick();
    check("req_during_rst", 32'(bus.imem_req), 32'h0);
    tick();
    rst = 1'b0;
    idle();
    check("first_req", 32'(bus.imem_req), 32'h1);
    check("first_addr", bus.imem_addr, 32'h0000_3000);

    bus.imem_ready = 1'b1;
    tick();
    idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2008_0005;
    tick();
    idle();
    check("exec_instr", instr, 32'h2008_0005);
    check("exec_valid", 32'(instr_valid), 32'h1);
    retire = 1'b1;
    npc_op = NPC_PLUS4;
    tick();
    idle();
    check("plus4_addr", bus.imem_addr, 32'h0000_3004);

    for (int unsigned k = 0; k < 3; k++) do_instr(32'h1000_0000 + k, NPC_PLUS4, '0, '0, '0);
    check("pc_3010", pc, 32'h0000_3010);
    do_instr(32'h1000_0010, NPC_BRANCH, 16'hFFFC, '0, '0);
    check("branch_addr", bus.imem_addr, 32'h0000_3004);
    for (int unsigned k = 0; k < 3; k++) do_instr(32'h1100_0000 + k, NPC_PLUS4, '0, '0, '0);
    do_instr(32'h1200_0000, NPC_JUMP, '0, 26'h000_0C10, '0);
    check("jump_addr", bus.imem_addr, 32'h0000_3040);

    // Ready stalls with junk rvalid and retire, then delayed response
    for (int unsigned k = 0; k < 3; k++) begin
      idle();
      retire          = 1'b1;
      bus.imem_rvalid = 1'b1;
      #1;
      check("stall_req", 32'(bus.imem_req), 32'h1);
      check("stall_addr", bus.imem_addr, 32'h0000_3040);
      tick();
    end
    idle();
    bus.imem_ready = 1'b1;
    check("accept_addr", bus.imem_addr, 32'h0000_3040);
    tick();
    for (int unsigned k = 0; k < 2; k++) begin
      idle();
      retire = 1'b1;
      #1;
      check("wait_valid", 32'(instr_valid), 32'h0);
      tick();
    end
    idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hABCD_0001;
    tick();
    idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    idle();
    check("spurious_instr", instr, 32'hABCD_0001);
    check("held_valid", 32'(instr_valid), 32'h1);
    retire = 1'b1;
    npc_op = NPC_PLUS4;
    tick();
    idle();
    check("after_stall_addr", bus.imem_addr, 32'h0000_3044);

    do_instr(32'h1300_0000, NPC_JR, '0, '0, 32'h0000_3022);
    check("jr_addr", bus.imem_addr, exp_jr_addr);
    check("jr_misalign", 32'(pc_misalign), 32'(exp_mis));
    do_instr(32'h1300_0001, NPC_PLUS4, '0, '0, '0);
    check("misalign_sticky", 32'(pc_misalign), 32'(exp_mis));

    // Reset while a fetch is outstanding
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    do_instr(32'h1400_0000, NPC_PLUS4, '0, '0, '0);
    do_instr(32'h1400_0001, NPC_PLUS4, '0, '0, '0);
    bus.imem_ready = 1'b1;
    tick();
    idle();
    check("wait_pc_3008", pc, 32'h0000_3008);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("rst_req", 32'(bus.imem_req), 32'h1);
    check("rst_addr", bus.imem_addr, 32'h0000_3000);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_misalign", 32'(pc_misalign), 32'h0);

    do_instr(32'h1500_0000, NPC_BRANCH, 16'hF3FE, '0, '0);
    check("branch_wrap", bus.imem_addr, 32'hFFFF_FFFC);
    do_instr(32'h1500_0001, NPC_PLUS4, '0, '0, '0);
    check("plus4_wrap", bus.imem_addr, 32'h0000_0000);
    check("plus4_wrap_p4", pc_plus4, 32'h0000_0004);

    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
